v_nibble_rx: RTL



---
 rtl/v_nibble_pkg.sv | 15 +
 rtl/v_sync2.sv | 31 +++
 rtl/v_nibble_rx.sv | 130 +++++++++++++
 3 files changed

// File: rtl/v_nibble_pkg.sv
// Shared constants for the nibble receiver: FSM encoding and frame geometry.
package v_nibble_pkg;

  localparam int unsigned NIBBLE_W   = 4;
  localparam logic        IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } rx_state_e;

endpackage : v_nibble_pkg

// File: rtl/v_sync2.sv
// Two-flop synchronizer for an asynchronous level input; resets to the idle level.
// Ports:
//   clk_i  - destination clock
//   rst_ni - asynchronous active-low reset
//   d_i    - asynchronous input
//   q_o    - synchronized output (second flop)
module v_sync2
  import v_nibble_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= IDLE_LEVEL;
      s2_q <= IDLE_LEVEL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule : v_sync2

// File: rtl/v_nibble_rx.sv
// Framed serial receiver: start bit, 4 data bits LSB first, stop bit.
// Presents each good nibble on DOUT with a one-cycle LOAD strobe that feeds
// the downstream holding register (D/CE).
// Ports:
//   C     - system clock
//   RST_N - asynchronous active-low reset
//   SIN   - asynchronous serial line, idle high
//   DOUT  - last correctly framed nibble (registered)
//   LOAD  - one-cycle strobe, DOUT newly valid (registered)
//   FERR  - one-cycle pulse, stop bit sampled low (registered)
//   BUSY  - combinational, FSM not in IDLE
module v_nibble_rx
  import v_nibble_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                C,
  input  logic                RST_N,
  input  logic                SIN,
  output logic [NIBBLE_W-1:0] DOUT,
  output logic                LOAD,
  output logic                FERR,
  output logic                BUSY
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(NIBBLE_W);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NIBBLE_W - 1);

  rx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NIBBLE_W-1:0]   shift_q, shift_d;
  logic [NIBBLE_W-1:0]   dout_q, dout_d;
  logic                  load_q, load_d;
  logic                  ferr_q, ferr_d;
  logic                  s2;

  v_sync2 u_sync (
    .clk_i  (C),
    .rst_ni (RST_N),
    .d_i    (SIN),
    .q_o    (s2)
  );

  // State and datapath registers.
  always_ff @(posedge C or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      dout_q  <= {NIBBLE_W{1'b1}};
      load_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      load_q  <= load_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state and datapath updates; the bit counter restarts on every transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    load_d  = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (s2 == 1'b0) state_d = START;
      end
      START: begin
        // Re-check the line mid start bit to reject short glitches.
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = (s2 == 1'b0) ? DATA : IDLE;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          shift_d[idx_q] = s2;
          if (idx_q == IDX_LAST) state_d = STOP;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (s2 == 1'b1) begin
            dout_d  = shift_q;
            load_d  = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HI;
          end
        end
      end
      WAIT_HI: begin
        // Hold off new start detection until the line recovers high.
        cnt_d = '0;
        if (s2 == 1'b1) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign DOUT = dout_q;
  assign LOAD = load_q;
  assign FERR = ferr_q;
  assign BUSY = (state_q != IDLE);

endmodule : v_nibble_rx
